// File: rtl/jtag_vdr_mc_pkg.sv
// Shared definitions for the multi-channel JTAG virtual data register.
package jtag_vdr_mc_pkg;

  // Decoded virtual-JTAG instruction opcodes
  typedef enum logic [2:0] {
    OpIdent  = 3'd0,
    OpRaddr  = 3'd1,
    OpWaddr  = 3'd2,
    OpRdata  = 3'd3,
    OpWdata  = 3'd4,
    OpFlags  = 3'd5,
    OpChan   = 3'd6,
    OpBypass = 3'd7
  } op_e;

  // Width of the active-channel index (up to 8 channels)
  localparam int unsigned ChanW = 3;

endpackage

// File: rtl/jtag_vdr_mc_if.sv
// RAM-side bus of the VDR: per-channel read data in, shared write data,
// one-hot write strobes and packed per-channel address counters out.
interface jtag_vdr_mc_if #(
  parameter int unsigned DR_W   = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned NCH    = 2
);
  logic [NCH*DR_W-1:0]   rdata_in;
  logic [DR_W-1:0]       wdata_out;
  logic [NCH-1:0]        wram_we;
  logic [NCH*ADDR_W-1:0] raddr_out;
  logic [NCH*ADDR_W-1:0] waddr_out;

  modport master (
    input  rdata_in,
    output wdata_out, wram_we, raddr_out, waddr_out
  );

  modport slave (
    output rdata_in,
    input  wdata_out, wram_we, raddr_out, waddr_out
  );
endinterface

// File: rtl/jtag_vdr_chan.sv
// Per-channel read/write address counters. A load always beats a
// same-edge increment; counters wrap silently.
module jtag_vdr_chan #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              tck,
  input  logic              rst_n,
  input  logic              raddr_ld,
  input  logic              waddr_ld,
  input  logic [ADDR_W-1:0] ld_val,
  input  logic              raddr_inc,
  input  logic              waddr_inc,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W-1:0] waddr
);

  // Read address counter
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n)         raddr <= '0;
    else if (raddr_ld)  raddr <= ld_val;
    else if (raddr_inc) raddr <= raddr + ADDR_W'(1);
  end

  // Write address counter
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n)         waddr <= '0;
    else if (waddr_ld)  waddr <= ld_val;
    else if (waddr_inc) waddr <= waddr + ADDR_W'(1);
  end

endmodule

// File: rtl/jtag_vdr_mc.sv
// Multi-channel JTAG virtual data register with streaming RAM access.
// Define JTAG_VDR_BURST_EN to stream whole words inside one SHIFT_DR
// (write latch and read reload at every word boundary); without it each
// capture/update pair moves exactly one word.
module jtag_vdr_mc
  import jtag_vdr_mc_pkg::*;
#(
  parameter int unsigned DR_W       = 32,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned NCH        = 2,
  parameter logic [31:0] IDENT      = 32'h97d2f9d0,
  parameter logic [63:0] FLAGS_INIT = 64'h99
) (
  input  logic             tck,
  input  logic             rst_n,
  input  logic             tdi,
  output logic             vdr_tdo,
  input  logic             capture_dr,
  input  logic             shift_dr,
  input  logic             update_dr,
  input  logic [2:0]       op,
  jtag_vdr_mc_if.master    mem,
  output logic [DR_W-1:0]  flags_out,
  output logic [ChanW-1:0] chan_out
);

`ifdef JTAG_VDR_BURST_EN
  localparam bit BurstEn = 1'b1;
`else
  localparam bit BurstEn = 1'b0;
`endif

  localparam int unsigned   BCW      = $clog2(DR_W);
  localparam logic [BCW-1:0] BcLast  = BCW'(DR_W - 1);
  localparam logic [63:0]   IdentExt = {32'h0, IDENT};
  localparam logic [DR_W-1:0] IdentW = IdentExt[DR_W-1:0];
  localparam logic [DR_W-1:0] FlagsW = FLAGS_INIT[DR_W-1:0];

  op_e opc;
  assign opc = op_e'(op);

  logic [DR_W-1:0]  vdr_q, vdr_d, wdata_q, flags_q, rdata_sel;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [ChanW-1:0] chan_q, chan_d, wr_chan_q, rinc_chan_q;
  logic             word_end, lat_ev, blat_q, blat_d, rinc_q, rinc_d;
  logic             wr_v_q, winc_q;
  logic [NCH-1:0]   we_q, wr_onehot, raddr_ld, waddr_ld, raddr_inc, waddr_inc;
  logic [NCH*ADDR_W-1:0] raddr_v, waddr_v;

  // Select the active channel's read data and the latched write channel strobe
  always_comb begin
    rdata_sel = '0;
    wr_onehot = '0;
    for (int i = 0; i < NCH; i++) begin
      if (chan_q == ChanW'(i))    rdata_sel = mem.rdata_in[i*DR_W +: DR_W];
      if (wr_chan_q == ChanW'(i)) wr_onehot[i] = 1'b1;
    end
  end

  // Shift that completes a DR_W-bit word
  assign word_end = shift_dr && !capture_dr && (bcnt_q == BcLast);

  // Next state of shift register, bit counter, channel and event strobes
  always_comb begin
    vdr_d  = vdr_q;
    bcnt_d = bcnt_q;
    chan_d = chan_q;
    if (capture_dr) begin
      case (opc)
        OpIdent: vdr_d = IdentW;
        OpRdata: vdr_d = rdata_sel;
        OpFlags: vdr_d = flags_q;
        OpChan:  vdr_d = {{(DR_W-ChanW){1'b0}}, chan_q};
        default: ;
      endcase
    end else if (shift_dr) begin
      if (BurstEn && opc == OpRdata && word_end) vdr_d = rdata_sel;
      else                                       vdr_d = {tdi, vdr_q[DR_W-1:1]};
    end

    if (capture_dr || !(opc == OpRdata || opc == OpWdata)) bcnt_d = '0;
    else if (shift_dr) bcnt_d = (bcnt_q == BcLast) ? '0 : bcnt_q + BCW'(1);

    // Out-of-range channel numbers are ignored
    if (update_dr && opc == OpChan && vdr_q < DR_W'(NCH)) chan_d = vdr_q[ChanW-1:0];

    rinc_d = (capture_dr && opc == OpRdata) || (BurstEn && word_end && opc == OpRdata);
    blat_d = BurstEn && word_end && opc == OpWdata;
    lat_ev = BurstEn ? blat_q : (update_dr && opc == OpWdata);
  end

  // Core registers: shift register, bit counter, channel, flags
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      vdr_q   <= '0;
      bcnt_q  <= '0;
      chan_q  <= '0;
      flags_q <= FlagsW;
    end else begin
      vdr_q  <= vdr_d;
      bcnt_q <= bcnt_d;
      chan_q <= chan_d;
      if (update_dr && opc == OpFlags) flags_q <= vdr_q;
    end
  end

  // Write pipeline: latch at L, strobe L+1..L+2, address bump at L+2;
  // read pipeline: address bump one edge after capture/reload
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      wdata_q     <= '0;
      wr_chan_q   <= '0;
      wr_v_q      <= 1'b0;
      we_q        <= '0;
      winc_q      <= 1'b0;
      blat_q      <= 1'b0;
      rinc_q      <= 1'b0;
      rinc_chan_q <= '0;
    end else begin
      blat_q <= blat_d;
      wr_v_q <= lat_ev;
      if (lat_ev) begin
        wdata_q   <= vdr_q;
        wr_chan_q <= chan_q;
      end
      we_q <= wr_v_q ? wr_onehot : '0;
      // A WADDR load on the target channel cancels the pending bump
      winc_q <= wr_v_q && !(update_dr && opc == OpWaddr && chan_q == wr_chan_q);
      rinc_q <= rinc_d;
      if (rinc_d) rinc_chan_q <= chan_q;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    assign raddr_ld[c]  = update_dr && opc == OpRaddr && chan_q == ChanW'(c);
    assign waddr_ld[c]  = update_dr && opc == OpWaddr && chan_q == ChanW'(c);
    assign raddr_inc[c] = rinc_q && rinc_chan_q == ChanW'(c);
    assign waddr_inc[c] = winc_q && wr_chan_q == ChanW'(c);

    jtag_vdr_chan #(
      .ADDR_W(ADDR_W)
    ) u_chan (
      .tck      (tck),
      .rst_n    (rst_n),
      .raddr_ld (raddr_ld[c]),
      .waddr_ld (waddr_ld[c]),
      .ld_val   (vdr_q[ADDR_W-1:0]),
      .raddr_inc(raddr_inc[c]),
      .waddr_inc(waddr_inc[c]),
      .raddr    (raddr_v[c*ADDR_W +: ADDR_W]),
      .waddr    (waddr_v[c*ADDR_W +: ADDR_W])
    );
  end

  assign vdr_tdo       = vdr_q[0];
  assign flags_out     = flags_q;
  assign chan_out      = chan_q;
  assign mem.wdata_out = wdata_q;
  assign mem.wram_we   = we_q;
  assign mem.raddr_out = raddr_v;
  assign mem.waddr_out = waddr_v;

endmodule

// File: tb/tb_jtag_vdr_mc.sv
// Directed bench for jtag_vdr_mc (DR_W=32, ADDR_W=16, NCH=2).
module tb_jtag_vdr_mc;
  import jtag_vdr_mc_pkg::*;

`ifdef JTAG_VDR_BURST_EN
  localparam bit BurstEn = 1'b1;
`else
  localparam bit BurstEn = 1'b0;
`endif

  logic        tck, rst_n, tdi, vdr_tdo, capture_dr, shift_dr, update_dr;
  logic [2:0]  op;
  logic [31:0] flags_out;
  logic [2:0]  chan_out;

  jtag_vdr_mc_if #(.DR_W(32), .ADDR_W(16), .NCH(2)) mem_if ();

  jtag_vdr_mc #(
    .DR_W(32), .ADDR_W(16), .NCH(2)
  ) dut (
    .tck       (tck),
    .rst_n     (rst_n),
    .tdi       (tdi),
    .vdr_tdo   (vdr_tdo),
    .capture_dr(capture_dr),
    .shift_dr  (shift_dr),
    .update_dr (update_dr),
    .op        (op),
    .mem       (mem_if),
    .flags_out (flags_out),
    .chan_out  (chan_out)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  // Memory model: rdata = addr*3, two-cycle latency, per channel
  logic [31:0] ra_d1, ra_d2;
  always @(posedge tck) begin
    ra_d1 <= mem_if.raddr_out;
    ra_d2 <= ra_d1;
  end
  assign mem_if.rdata_in = {32'(ra_d2[31:16]) * 32'd3, 32'(ra_d2[15:0]) * 32'd3};

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe recorder
  int          nstb = 0;
  logic [1:0]  stb_we[8];
  logic [31:0] stb_data[8];
  logic [31:0] stb_waddr[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge tck);
    #1;
    if (mem_if.wram_we != 2'b00) begin
      if (nstb < 8) begin
        stb_we[nstb]    = mem_if.wram_we;
        stb_data[nstb]  = mem_if.wdata_out;
        stb_waddr[nstb] = mem_if.waddr_out;
      end
      nstb++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic scan(input op_e o, input logic [159:0] din, input int nbits,
                      output logic [159:0] dout);
    dout = '0;
    op = o;
    capture_dr = 1'b1; cycle(); capture_dr = 1'b0;
    shift_dr = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      tdi = din[i];
      dout[i] = vdr_tdo;
      cycle();
    end
    shift_dr = 1'b0; tdi = 1'b0;
    update_dr = 1'b1; cycle(); update_dr = 1'b0;
  endtask

  // Shift one word in and stop just after the latch edge L
  task automatic write_word(input logic [31:0] w);
    op = OpWdata;
    capture_dr = 1'b1; cycle(); capture_dr = 1'b0;
    shift_dr = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tdi = w[i];
      cycle();
    end
    tdi = 1'b0;
    if (BurstEn) begin
      cycle();
      shift_dr = 1'b0;
    end else begin
      shift_dr = 1'b0;
      update_dr = 1'b1; cycle(); update_dr = 1'b0;
    end
  endtask

  typedef struct {
    op_e         op;
    logic [31:0] din;
    logic [31:0] tdo;
    logic [2:0]  chan;
    logic [31:0] flags;
    logic [31:0] raddr;
    logic [31:0] waddr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [159:0] dout;
    logic [31:0]  words[4];
    logic [15:0]  exp_ld;
    logic [15:0]  rd_prev;
    int           stb0;

    vecs[0]  = '{OpIdent,  32'h0000_0000, 32'h97d2_f9d0, 3'd0, 32'h99,        32'h0, 32'h0};
    vecs[1]  = '{OpFlags,  32'h1234_5678, 32'h0000_0099, 3'd0, 32'h1234_5678, 32'h0, 32'h0};
    vecs[2]  = '{OpFlags,  32'h0000_00a5, 32'h1234_5678, 3'd0, 32'ha5,        32'h0, 32'h0};
    vecs[3]  = '{OpChan,   32'h0000_0001, 32'h0000_0000, 3'd1, 32'ha5,        32'h0, 32'h0};
    vecs[4]  = '{OpChan,   32'h0000_0005, 32'h0000_0001, 3'd1, 32'ha5,        32'h0, 32'h0};
    vecs[5]  = '{OpChan,   32'h0000_0002, 32'h0000_0001, 3'd1, 32'ha5,        32'h0, 32'h0};
    vecs[6]  = '{OpBypass, 32'hcafe_f00d, 32'h0000_0002, 3'd1, 32'ha5,        32'h0, 32'h0};
    vecs[7]  = '{OpRaddr,  32'h0000_0020, 32'hcafe_f00d, 3'd1, 32'ha5, 32'h0020_0000, 32'h0};
    vecs[8]  = '{OpChan,   32'h0000_0000, 32'h0000_0001, 3'd0, 32'ha5, 32'h0020_0000, 32'h0};
    vecs[9]  = '{OpWaddr,  32'h0001_1234, 32'h0000_0000, 3'd0, 32'ha5, 32'h0020_0000,
                 32'h0000_1234};
    vecs[10] = '{OpIdent,  32'hffff_ffff, 32'h97d2_f9d0, 3'd0, 32'ha5, 32'h0020_0000,
                 32'h0000_1234};
    vecs[11] = '{OpChan,   32'hffff_ffff, 32'h0000_0000, 3'd0, 32'ha5, 32'h0020_0000,
                 32'h0000_1234};
    vecs[12] = '{OpChan,   32'h0000_0001, 32'h0000_0000, 3'd1, 32'ha5, 32'h0020_0000,
                 32'h0000_1234};

    rst_n = 1'b0; tdi = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
    op = OpBypass;
    idle(2);
    check("rst wram_we", 64'(mem_if.wram_we), 64'h0);
    check("rst flags", 64'(flags_out), 64'h99);
    check("rst chan", 64'(chan_out), 64'h0);
    check("rst tdo", 64'(vdr_tdo), 64'h0);
    check("rst addrs", {mem_if.raddr_out, mem_if.waddr_out}, 64'h0);
    check("rst wdata", 64'(mem_if.wdata_out), 64'h0);
    rst_n = 1'b1;
    idle(2);

    // Table: one full 32-bit scan per row
    for (int i = 0; i < 13; i++) begin
      scan(vecs[i].op, 160'(vecs[i].din), 32, dout);
      check($sformatf("vec%0d tdo", i),   64'(dout[31:0]), 64'(vecs[i].tdo));
      check($sformatf("vec%0d chan", i),  64'(chan_out), 64'(vecs[i].chan));
      check($sformatf("vec%0d flags", i), 64'(flags_out), 64'(vecs[i].flags));
      check($sformatf("vec%0d raddr", i), 64'(mem_if.raddr_out), 64'(vecs[i].raddr));
      check($sformatf("vec%0d waddr", i), 64'(mem_if.waddr_out), 64'(vecs[i].waddr));
    end

    // Single write on ch1 at WADDR 0x0010
    scan(OpWaddr, 160'(32'h0010), 32, dout);
    stb0 = nstb;
    write_word(32'hdeadbeef);
    check("wr L wdata", 64'(mem_if.wdata_out), 64'hdeadbeef);
    check("wr L we", 64'(mem_if.wram_we), 64'h0);
    cycle();
    check("wr L+1 we", 64'(mem_if.wram_we), 64'h2);
    check("wr L+1 waddr", 64'(mem_if.waddr_out), 64'h0010_1234);
    cycle();
    check("wr L+2 we", 64'(mem_if.wram_we), 64'h0);
    check("wr L+2 waddr", 64'(mem_if.waddr_out), 64'h0011_1234);
    idle(3);
    check("wr strobe count", 64'(nstb - stb0), 64'd1);

    // WADDR load one edge after L cancels the pending increment
    exp_ld = BurstEn ? 16'h1234 : 16'h2468;
    write_word(32'h0000_2468);
    op = OpWaddr; update_dr = 1'b1; cycle(); update_dr = 1'b0;
    check("wcancel L+1 we", 64'(mem_if.wram_we), 64'h2);
    check("wcancel L+1 waddr", 64'(mem_if.waddr_out[31:16]), 64'(exp_ld));
    idle(2);
    check("wcancel settled waddr", 64'(mem_if.waddr_out[31:16]), 64'(exp_ld));

    // Read on ch1 from address 5
    scan(OpRaddr, 160'(32'h5), 32, dout);
    idle(3);
    scan(OpRdata, 160'(0), 32, dout);
    rd_prev = BurstEn ? 16'h7 : 16'h6;
    check("rd tdo", 64'(dout[31:0]), 64'hf);
    check("rd raddr ch1", 64'(mem_if.raddr_out[31:16]), 64'(rd_prev));
    check("rd raddr ch0", 64'(mem_if.raddr_out[15:0]), 64'h0);

    // RADDR update on the same edge as the capture-driven increment
    idle(3);
    op = OpRdata; capture_dr = 1'b1; cycle(); capture_dr = 1'b0;
    op = OpRaddr; update_dr = 1'b1; cycle(); update_dr = 1'b0;
    check("rcollide raddr", 64'(mem_if.raddr_out[31:16]), 64'(rd_prev * 16'd3));
    idle(2);
    check("rcollide settled", 64'(mem_if.raddr_out[31:16]), 64'(rd_prev * 16'd3));

    if (BurstEn) begin
      // Four streamed writes across the address wrap, then 8 stray bits
      words[0] = 32'ha0a0_0001; words[1] = 32'hb1b1_0002;
      words[2] = 32'hc2c2_0003; words[3] = 32'hd3d3_0004;
      scan(OpWaddr, 160'(32'hfffe), 32, dout);
      nstb = 0;
      scan(OpWdata, {24'h0, 8'h0, words[3], words[2], words[1], words[0]}, 136, dout);
      idle(4);
      check("burst strobe count", 64'(nstb), 64'd4);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("burst%0d data", i), 64'(stb_data[i]), 64'(words[i]));
        check($sformatf("burst%0d addr", i), 64'(stb_waddr[i][31:16]),
              64'(16'hfffe + 16'(i)));
        check($sformatf("burst%0d we", i), 64'(stb_we[i]), 64'h2);
      end
      check("burst final waddr", 64'(mem_if.waddr_out[31:16]), 64'h0002);

      // Streamed read of three words from 0x20
      scan(OpRaddr, 160'(32'h20), 32, dout);
      idle(3);
      scan(OpRdata, 160'(0), 96, dout);
      check("bread w0", 64'(dout[31:0]), 64'h60);
      check("bread w1", 64'(dout[63:32]), 64'h63);
      check("bread w2", 64'(dout[95:64]), 64'h66);
      check("bread raddr", 64'(mem_if.raddr_out[31:16]), 64'h24);
    end

    // Reset while a write strobe is pending
    write_word(32'h5555_aaaa);
    #1;
    rst_n = 1'b0;
    #1;
    stb0 = nstb;
    check("mrst wram_we", 64'(mem_if.wram_we), 64'h0);
    check("mrst addrs", {mem_if.raddr_out, mem_if.waddr_out}, 64'h0);
    check("mrst flags", 64'(flags_out), 64'h99);
    check("mrst chan", 64'(chan_out), 64'h0);
    check("mrst wdata", 64'(mem_if.wdata_out), 64'h0);
    idle(2);
    rst_n = 1'b1;
    idle(5);
    check("mrst no strobe", 64'(nstb - stb0), 64'd0);
    check("mrst waddr held", 64'(mem_if.waddr_out), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
